alu_seq: RTL and testbench

//  Parametrised, registered successor to the lab datapath ALU: WIDTH-bit operands, 8 ops.

---
 rtl/alu_seq.sv | 178 +++++++++++++++++
 tb/tb_alu_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module     : alu_seq
// Description: Registered WIDTH-bit ALU with 8 ops, an iterative shift-add
//              multiplier and a start/busy/done handshake.
// Revision   : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] val_A,
    input  logic [WIDTH-1:0] val_B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_out,
    output logic             Z,
    output logic             N,
    output logic             V
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LSL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 z_q, z_d;
    logic                 n_q, n_d;
    logic                 v_q, v_d;
    logic                 done_q, done_d;

    logic                 mul_sel;
    logic [WIDTH-1:0]     single_res;
    logic                 single_v;
    logic [2*WIDTH-1:0]   mul_step;

    generate
        if (MUL_EN) begin : g_mul_on
            assign mul_sel = (alu_op == OP_MUL);
        end else begin : g_mul_off
            assign mul_sel = 1'b0;
        end
    endgenerate

    // Single-cycle datapath; op 111 lands in default (result 0) when the multiplier is disabled.
    always_comb begin
        single_res = '0;
        single_v   = 1'b0;
        case (alu_op)
            OP_ADD: begin
                single_res = val_A + val_B;
                single_v   = (val_A[WIDTH-1] == val_B[WIDTH-1]) &&
                             (single_res[WIDTH-1] != val_A[WIDTH-1]);
            end
            OP_SUB: begin
                single_res = val_A - val_B;
                single_v   = (val_A[WIDTH-1] != val_B[WIDTH-1]) &&
                             (single_res[WIDTH-1] != val_A[WIDTH-1]);
            end
            OP_AND:  single_res = val_A & val_B;
            OP_NOT:  single_res = ~val_B;
            OP_OR:   single_res = val_A | val_B;
            OP_XOR:  single_res = val_A ^ val_B;
            OP_LSL:  single_res = val_A << val_B[SHW-1:0];
            default: single_res = '0;
        endcase
    end

    // Multiplicand shifts left and multiplier right, so each step only inspects bit 0.
    assign mul_step = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        out_d    = out_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mul_sel) begin
                        state_d  = ST_MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, val_A};
                        mplier_d = val_B;
                        count_d  = '0;
                    end else begin
                        out_d  = single_res;
                        z_d    = (single_res == '0);
                        n_d    = single_res[WIDTH-1];
                        v_d    = single_v;
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = mul_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == LAST_STEP) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    out_d   = mul_step[WIDTH-1:0];
                    z_d     = (mul_step[WIDTH-1:0] == '0);
                    n_d     = mul_step[WIDTH-1];
                    v_d     = |mul_step[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            out_q    <= out_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (state_q == ST_MUL);
    assign done    = done_q;
    assign alu_out = out_q;
    assign Z       = z_q;
    assign N       = n_q;
    assign V       = v_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module     : tb_alu_seq
// Description: Self-checking bench for alu_seq against a behavioural model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 16;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, NOT_ = 3'd3;
    localparam logic [2:0] OR_ = 3'd4, XOR_ = 3'd5, LSL = 3'd6, MUL = 3'd7;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   alu_op;
    logic [W-1:0] val_A, val_B;
    logic         busy, done;
    logic [W-1:0] alu_out;
    logic         Z, N, V;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: committed outputs, pending multiply result and cycles left.
    logic [W-1:0] m_out, p_out;
    logic         m_z, m_n, m_v, m_done, p_z, p_n, p_v;
    int           m_rem;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .alu_op  (alu_op),
        .val_A   (val_A),
        .val_B   (val_B),
        .busy    (busy),
        .done    (done),
        .alu_out (alu_out),
        .Z       (Z),
        .N       (N),
        .V       (V)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic z, output logic n, output logic v);
        int     sa, sb, full;
        longint prod;
        sa = int'($signed(a));
        sb = int'($signed(b));
        v  = 1'b0;
        case (op)
            ADD: begin
                full = sa + sb;
                r    = W'(a + b);
                v    = (full > 2**(W-1) - 1) || (full < -(2**(W-1)));
            end
            SUB: begin
                full = sa - sb;
                r    = W'(a - b);
                v    = (full > 2**(W-1) - 1) || (full < -(2**(W-1)));
            end
            AND_: r = a & b;
            NOT_: r = ~b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            LSL:  r = W'(a << (b % W));
            default: begin
                prod = longint'(a) * longint'(b);
                r    = prod[W-1:0];
                v    = (prod >> W) != 0;
            end
        endcase
        z = (r == '0);
        n = r[W-1];
    endtask

    task automatic tick(input logic r, input logic s, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        reset  = r;
        start  = s;
        alu_op = op;
        val_A  = a;
        val_B  = b;
        @(posedge clk);
        #1;
        if (r) begin
            m_out = '0; m_z = 0; m_n = 0; m_v = 0; m_done = 0; m_rem = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_out = p_out; m_z = p_z; m_n = p_n; m_v = p_v; m_done = 1;
                end
            end else if (s) begin
                ref_op(op, a, b, p_out, p_z, p_n, p_v);
                if (op == MUL) m_rem = W;
                else begin
                    m_out = p_out; m_z = p_z; m_n = p_n; m_v = p_v; m_done = 1;
                end
            end
        end
        chk("busy",    W'(busy),    W'(m_rem > 0));
        chk("done",    W'(done),    W'(m_done));
        chk("alu_out", alu_out,     m_out);
        chk("Z",       W'(Z),       W'(m_z));
        chk("N",       W'(N),       W'(m_n));
        chk("V",       W'(V),       W'(m_v));
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 3'($urandom), 16'($urandom), 16'($urandom));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int cnt, guard, dn;
        reset = 1'b1; start = 1'b0; alu_op = '0; val_A = '0; val_B = '0;
        m_out = '0; m_z = 0; m_n = 0; m_v = 0; m_done = 0; m_rem = 0;
        p_out = '0; p_z = 0; p_n = 0; p_v = 0;

        tick(1, 0, ADD, 0, 0);
        tick(1, 0, ADD, 0, 0);
        chk("rst_out",  alu_out, 16'h0000);
        chk("rst_znv",  W'({Z, N, V}), 16'h0000);
        chk("rst_bd",   W'({busy, done}), 16'h0000);
        idle();

        tick(0, 1, ADD, 16'h7FFF, 16'h0001);
        chk("t1_done", W'(done), 16'h0001);
        chk("t1_out",  alu_out, 16'h8000);
        chk("t1_znv",  W'({Z, N, V}), 16'h0003);
        idle();
        chk("t1_pulse", W'(done), 16'h0000);

        tick(0, 1, SUB, 16'h0005, 16'h0005);
        chk("t2a_out", alu_out, 16'h0000);
        chk("t2a_znv", W'({Z, N, V}), 16'h0004);
        tick(0, 1, SUB, 16'h8000, 16'h0001);
        chk("t2b_out", alu_out, 16'h7FFF);
        chk("t2b_znv", W'({Z, N, V}), 16'h0001);

        tick(0, 1, MUL, 16'd300, 16'd7);
        cnt = 0; guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            cnt++; guard++;
            tick(0, 1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom));
        end
        chk("t3_busy_cycles", W'(cnt), 16'd16);
        chk("t3_done", W'(done), 16'h0001);
        chk("t3_out",  alu_out, 16'd2100);
        chk("t3_v",    W'(V), 16'h0000);

        tick(0, 1, MUL, 16'h0100, 16'h0100);
        idle(); idle(); idle();
        tick(0, 1, ADD, 16'h0001, 16'h0001);
        dn = 0;
        if (done) dn++;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (done) begin
                dn++;
                chk("t4_out", alu_out, 16'h0000);
                chk("t4_zv",  W'({Z, V}), 16'h0003);
            end
        end
        chk("t4_done_pulses", W'(dn), 16'd1);

        tick(0, 1, MUL, 16'd9, 16'd9);
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            guard++;
            idle();
        end
        chk("t5_mul_done", W'(done), 16'h0001);
        chk("t5_mul_out",  alu_out, 16'd81);
        tick(0, 1, ADD, 16'd2, 16'd3);
        chk("t5_done", W'(done), 16'h0001);
        chk("t5_out",  alu_out, 16'd5);

        tick(0, 1, MUL, 16'd1234, 16'd5678);
        repeat (7) idle();
        tick(1, 0, ADD, 16'd0, 16'd0);
        chk("t6_busy", W'(busy), 16'h0000);
        chk("t6_out",  alu_out, 16'h0000);
        chk("t6_znvd", W'({Z, N, V, done}), 16'h0000);
        idle();
        chk("t6_nodone", W'(done), 16'h0000);
        tick(0, 1, AND_, 16'hF0F0, 16'h0FF0);
        chk("t6_and", alu_out, 16'h00F0);

        tick(0, 1, LSL, 16'h0001, 16'h0013);
        chk("lsl_out", alu_out, 16'h0008);
        tick(0, 1, NOT_, 16'h1234, 16'h00FF);
        chk("not_out", alu_out, 16'hFF00);
        chk("not_n",   W'(N), 16'h0001);

        for (int i = 0; i < 3000; i++) begin
            tick(1'(($urandom % 100) == 0), 1'(($urandom % 3) != 0),
                 3'($urandom), pick(), pick());
        end
        repeat (20) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
